decoder_3to8_hold: RTL and testbench

DECODER_3TO8_HOLD -- requirements
Module: decoder_3to8_hold

---
 rtl/decoder_pkg.sv | 23 ++
 rtl/code_fifo.sv | 82 ++++++++
 rtl/decoder_3to8_hold.sv | 121 ++++++++++++
 tb/tb_decoder_3to8_hold.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared widths, FSM state encoding and the code-to-one-hot helper for the hold decoder.
// Pure definitions: no logic, no latency, no flow control.
package decoder_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef logic [CODE_W-1:0]   code_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic onehot_t code_to_onehot(input code_t code);
        onehot_t word;
        word       = '0;
        word[code] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Generic synchronous FIFO with flush; pop data is the head entry, visible combinationally.
// Write-to-read latency one clock; push ignored when full, pop ignored when empty, flush wins.
module code_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Guarding here keeps the pointers consistent even if a caller misbehaves.
    assign do_push = push_i & ~full_o  & ~flush_i;
    assign do_pop  = pop_i  & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by the pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/decoder_3to8_hold.sv
// Buffers 3-bit codes and drives each as a registered one-hot word for HOLD_CYCLES clocks.
// First word one clock after acceptance; din_ready drops only when the code FIFO is full.
module decoder_3to8_hold
    import decoder_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CODE_W-1:0]   din,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic                flush,
    output logic [ONEHOT_W-1:0] dout,
    output logic                dout_valid,
    output logic                busy
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            hold_cnt_q, hold_cnt_d;
    onehot_t                     dout_q, dout_d;
    logic                        dout_valid_q, dout_valid_d;

    logic                        fifo_push;
    logic                        fifo_pop;
    code_t                       fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign din_ready = ~fifo_full;
    assign fifo_push = din_valid & din_ready & ~flush;

    code_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_code_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifo_push),
        .push_dat_i (din),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .flush_i    (flush),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        fifo_pop     = 1'b0;

        if (flush) begin
            state_d      = IDLE;
            hold_cnt_d   = '0;
            dout_d       = '0;
            dout_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        state_d      = HOLD;
                        hold_cnt_d   = HOLD_RELOAD;
                        dout_d       = code_to_onehot(fifo_head);
                        dout_valid_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - CNT_ONE;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next word so there is no idle gap.
                        fifo_pop     = 1'b1;
                        hold_cnt_d   = HOLD_RELOAD;
                        dout_d       = code_to_onehot(fifo_head);
                        dout_valid_d = 1'b1;
                    end else begin
                        state_d      = IDLE;
                        dout_d       = '0;
                        dout_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    hold_cnt_d   = '0;
                    dout_d       = '0;
                    dout_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (fifo_count != '0) | (state_q == HOLD);

endmodule

// File: tb/tb_decoder_3to8_hold.sv
// Directed bench for decoder_3to8_hold with default parameters (depth 4, hold 3).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_decoder_3to8_hold;

    logic       clk;
    logic       rst_n;
    logic [2:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       flush;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;

    int n_assert;
    int n_fail;

    decoder_3to8_hold dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Output must be zero or one-hot, and dout_valid must track a non-zero word, every cycle.
    always @(negedge clk) begin
        n_assert++;
        assert ($onehot0(dout) && (dout_valid === (dout != 8'h00))) else begin
            n_fail++;
            $error("FAIL onehot_monitor: observed dout=%0h valid=%0b, expected one-hot with matching valid",
                   dout, dout_valid);
        end
    end

    logic [7:0] btb_exp [9];
    logic [7:0] outq [$];
    logic [7:0] prev;
    int         code;
    int         vcycles;
    logic       acc;

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        din       = 3'd0;
        din_valid = 1'b0;
        flush     = 1'b0;

        // Reset state, checked before any clock edge
        #3;
        chk("rst_dout", dout, 8'h00);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_din_ready", din_ready, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_din_ready", din_ready, 1'b1);

        // Single code 5
        din = 3'd5; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("single_accept_dout", dout, 8'h00);
        chk("single_accept_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_hold_dout", dout, 8'b0010_0000);
            chk("single_hold_valid", dout_valid, 1'b1);
        end
        step();
        chk("single_end_dout", dout, 8'h00);
        chk("single_end_valid", dout_valid, 1'b0);
        chk("single_end_busy", busy, 1'b0);

        // Back-to-back 0, 7, 2
        btb_exp = '{8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h04, 8'h04, 8'h04};
        din = 3'd0; din_valid = 1'b1;
        step();
        chk("btb_first_latency", dout, 8'h00);
        for (int i = 0; i < 9; i++) begin
            din_valid = (i < 2);
            din       = (i == 0) ? 3'd7 : 3'd2;
            step();
            chk("btb_word", dout, btb_exp[i]);
        end
        din_valid = 1'b0;
        step();
        chk("btb_end_dout", dout, 8'h00);
        chk("btb_end_busy", busy, 1'b0);

        // Full FIFO: source offers 0..7 and holds each code until accepted
        code = 0; prev = 8'h00; vcycles = 0; outq.delete();
        for (int k = 0; k < 80; k++) begin
            if (code == 8 && !busy) break;
            din       = code[2:0];
            din_valid = (code < 8);
            if (k == 5) chk("full_ready_before_e5", din_ready, 1'b1);
            if (k == 6) chk("full_ready_dropped", din_ready, 1'b0);
            acc = din_valid & din_ready;
            step();
            if (acc) code++;
            if (dout_valid) vcycles++;
            if (dout_valid && dout != prev) outq.push_back(dout);
            prev = dout;
        end
        din_valid = 1'b0;
        chk("full_all_accepted", code, 8);
        chk("full_valid_cycles", vcycles, 24);
        chk("full_word_count", outq.size(), 8);
        for (int i = 0; i < 8 && i < outq.size(); i++) begin
            chk("full_order", outq[i], 32'h1 << i);
        end

        // Flush during the first hold cycle, with code 3 offered on the flush edge
        din = 3'd1; din_valid = 1'b1;
        step();
        din = 3'd2;
        step();
        chk("flush_first_word", dout, 8'h02);
        din = 3'd3; flush = 1'b1;
        step();
        flush = 1'b0; din_valid = 1'b0;
        chk("flush_dout", dout, 8'h00);
        chk("flush_valid", dout_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        chk("flush_ready", din_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("flush_no_stale", {busy, dout}, 9'h000);
        end

        // Asynchronous reset mid-HOLD with a code still queued
        din = 3'd4; din_valid = 1'b1;
        step();
        din = 3'd6;
        step();
        din_valid = 1'b0;
        chk("arst_pre_dout", dout, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", dout, 8'h00);
        chk("arst_valid", dout_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", din_ready, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("arst_no_stale", {busy, dout_valid, dout}, 10'h000);
        end

        // Every code decodes to 1 << code
        for (int c = 0; c < 8; c++) begin
            din = c[2:0]; din_valid = 1'b1;
            step();
            din_valid = 1'b0;
            step();
            chk("code_word", dout, 32'h1 << c);
            step();
            step();
            step();
            chk("code_end", dout, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
